uno_hand_ctrl: RTL and testbench

UNO_HAND_CTRL -- requirements
Module: uno_hand_ctrl

---
 rtl/uno_hand_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_uno_hand_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uno_hand_ctrl.sv
// uno_hand_ctrl: one player's UNO hand.
// The hand is kept sorted and compacted, with a cursor for choosing a card.
// Cards are dealt and drawn through a request/deliver handshake with the deck.
// A play or a pass is offered to the deck and held until the deck acknowledges it.
module uno_hand_ctrl #(
    parameter int unsigned DEPTH      = 15,
    parameter int unsigned INIT_CARDS = 7,
    parameter int unsigned IW         = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init,
    input  logic               i_start,
    input  logic               i_left,
    input  logic               i_right,
    input  logic               i_select,
    input  logic [5:0]         i_prev_card,
    input  logic               i_draw_two,
    input  logic               i_draw_four,
    output logic               o_draw,
    input  logic               i_drawn,
    input  logic [5:0]         i_drawed_card,
    output logic               o_out,
    output logic [5:0]         o_out_card,
    input  logic               i_check,
    output logic [DEPTH*7-1:0] o_hands,
    output logic [IW-1:0]      o_index,
    output logic [IW-1:0]      o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [5:0] PassCard = 6'h3F;

    typedef enum logic [3:0] {
        StIdle, StDeal, StWait, StPen, StSel, StColor, StPlay, StDraw, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      hand_q [DEPTH];
    logic [6:0]      hand_d [DEPTH];
    logic [6:0]      ins_hand [DEPTH];
    logic [6:0]      rem_hand [DEPTH];
    logic [IW-1:0]   count_q, count_d, index_q, index_d, left_q, left_d;
    logic [1:0]      colour_q, colour_d;
    logic [5:0]      pen_q, pen_d;
    logic [5:0]      out_card_q, out_card_d;
    logic            wait_q, wait_d, dealt_q, dealt_d;
    logic [5:0]      ins_card, cur_card;
    logic [DEPTH-1:0] below;
    logic            full, at_draw, cur_wild, cur_playable, req_done;

    function automatic logic [IW-1:0] clamp_idx(input logic [IW-1:0] idx,
                                                 input logic [IW-1:0] cnt);
        return (idx > cnt) ? cnt : idx;
    endfunction

    // Sorted insertion: slots below the new card stay, the rest shift up one.
    always_comb begin
        ins_card = i_drawed_card;
        if (i_drawed_card[3:0] == 4'd13 || i_drawed_card[3:0] == 4'd14) begin
            ins_card[5:4] = 2'b00;  // wilds are held colourless
        end
        for (int k = 0; k < DEPTH; k++) begin
            below[k] = hand_q[k][6] && (hand_q[k][5:0] < ins_card);
        end
        ins_hand[0] = below[0] ? hand_q[0] : {1'b1, ins_card};
        for (int k = 1; k < DEPTH; k++) begin
            if (below[k])          ins_hand[k] = hand_q[k];
            else if (below[k-1])   ins_hand[k] = {1'b1, ins_card};
            else                   ins_hand[k] = hand_q[k-1];
        end
    end

    // Cursor card lookup and removal at the cursor (higher slots shift down).
    always_comb begin
        cur_card = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (index_q == IW'(k)) cur_card = hand_q[k][5:0];
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            rem_hand[k] = (IW'(k) < index_q) ? hand_q[k] : hand_q[k+1];
        end
        rem_hand[DEPTH-1] = '0;
    end

    assign full         = (count_q == IW'(DEPTH));
    assign at_draw      = (index_q == count_q);
    assign cur_wild     = (cur_card[3:0] == 4'd13) || (cur_card[3:0] == 4'd14);
    assign cur_playable = cur_wild || (cur_card[5:4] == i_prev_card[5:4]) ||
                          ((cur_card[3:0] == i_prev_card[3:0]) && (cur_card[3:0] <= 4'd12));

    // Next-state logic: shared request engine for DEAL/PEN/DRAW, then the turn FSM.
    always_comb begin
        state_d    = state_q;
        hand_d     = hand_q;
        count_d    = count_q;
        index_d    = index_q;
        left_d     = left_q;
        colour_d   = colour_q;
        pen_d      = pen_q;
        out_card_d = out_card_q;
        wait_d     = wait_q;
        dealt_d    = dealt_q;
        o_draw     = 1'b0;
        req_done   = 1'b0;

        if (state_q == StDeal || state_q == StPen || state_q == StDraw) begin
            if (!wait_q) begin
                if (full) begin
                    req_done = 1'b1;  // no room: the card is skipped
                end else begin
                    o_draw = 1'b1;
                    wait_d = 1'b1;
                end
            end else if (i_drawn) begin
                hand_d   = ins_hand;
                count_d  = count_q + IW'(1);
                wait_d   = 1'b0;
                req_done = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: ;
            StDeal: begin
                if (req_done) begin
                    left_d = left_q - IW'(1);
                    if (left_q == IW'(1)) begin
                        state_d = StWait;
                        dealt_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (i_draw_two)  pen_d = pen_d + 6'd2;
                if (i_draw_four) pen_d = pen_d + 6'd4;
                if (i_start) begin
                    if (pen_d != '0) begin
                        state_d = StPen;
                    end else begin
                        state_d = StSel;
                        index_d = clamp_idx(index_q, count_q);
                    end
                end
            end
            StPen: begin
                if (req_done) begin
                    pen_d = pen_q - 6'd1;
                    if (pen_q == 6'd1) begin
                        state_d = StSel;
                        index_d = clamp_idx(index_q, count_d);
                    end
                end
            end
            StSel: begin
                if (i_select) begin
                    if (at_draw) begin
                        if (full) begin
                            out_card_d = PassCard;
                            state_d    = StPlay;
                        end else begin
                            state_d = StDraw;
                        end
                    end else if (cur_wild) begin
                        colour_d = 2'd0;
                        state_d  = StColor;
                    end else if (cur_playable) begin
                        out_card_d = cur_card;
                        hand_d     = rem_hand;
                        count_d    = count_q - IW'(1);
                        state_d    = StPlay;
                    end
                end else if (i_left ^ i_right) begin
                    if (i_right) index_d = at_draw ? '0 : index_q + IW'(1);
                    else         index_d = (index_q == '0) ? count_q : index_q - IW'(1);
                end
            end
            StColor: begin
                if (i_select) begin
                    out_card_d = {colour_q, cur_card[3:0]};
                    hand_d     = rem_hand;
                    count_d    = count_q - IW'(1);
                    state_d    = StPlay;
                end else if (i_left ^ i_right) begin
                    colour_d = i_right ? colour_q + 2'd1 : colour_q - 2'd1;
                end
            end
            StDraw: begin
                if (req_done) begin
                    out_card_d = PassCard;
                    state_d    = StPlay;
                end
            end
            StPlay: if (i_check) state_d = StDone;
            StDone: if (!i_start) state_d = StWait;
            default: state_d = StIdle;
        endcase

        // A new deal wins over anything in progress.
        if (i_init) begin
            state_d  = StDeal;
            for (int k = 0; k < DEPTH; k++) hand_d[k] = '0;
            count_d  = '0;
            index_d  = '0;
            left_d   = IW'(INIT_CARDS);
            colour_d = '0;
            pen_d    = '0;
            wait_d   = 1'b0;
            dealt_d  = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            for (int k = 0; k < DEPTH; k++) hand_q[k] <= '0;
            count_q    <= '0;
            index_q    <= '0;
            left_q     <= '0;
            colour_q   <= '0;
            pen_q      <= '0;
            out_card_q <= '0;
            wait_q     <= 1'b0;
            dealt_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hand_q     <= hand_d;
            count_q    <= count_d;
            index_q    <= index_d;
            left_q     <= left_d;
            colour_q   <= colour_d;
            pen_q      <= pen_d;
            out_card_q <= out_card_d;
            wait_q     <= wait_d;
            dealt_q    <= dealt_d;
        end
    end

    // Output mapping.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) o_hands[7*k +: 7] = hand_q[k];
    end

    assign o_out      = (state_q == StPlay);
    assign o_out_card = out_card_q;
    assign o_index    = index_q;
    assign o_count    = count_q;
    assign o_full     = full;
    assign o_empty    = dealt_q && (count_q == '0);

endmodule

// File: tb/tb_uno_hand_ctrl.sv
// Testbench for uno_hand_ctrl: a deck responder, a hand model and a play scoreboard.
module tb_uno_hand_ctrl;

    localparam int DEPTH = 15;

    logic clk, rst_n;
    logic init, start, left, right, sel, d2, d4, draw, drawn, out, check, full, empty;
    logic [5:0] prev, dcard, out_card;
    logic [DEPTH*7-1:0] hands;
    logic [3:0] index, count;

    logic b_init, b_start, b_left, b_right, b_sel, b_d2, b_d4, b_draw, b_drawn;
    logic b_out, b_check, b_full, b_empty;
    logic [5:0] b_prev, b_dcard, b_out_card;
    logic [8*7-1:0] b_hands;
    logic [3:0] b_index, b_count;

    int n_checks = 0;
    int n_errors = 0;

    uno_hand_ctrl #(.DEPTH(15), .INIT_CARDS(7)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_start(start), .i_left(left),
        .i_right(right), .i_select(sel), .i_prev_card(prev), .i_draw_two(d2),
        .i_draw_four(d4), .o_draw(draw), .i_drawn(drawn), .i_drawed_card(dcard),
        .o_out(out), .o_out_card(out_card), .i_check(check), .o_hands(hands),
        .o_index(index), .o_count(count), .o_full(full), .o_empty(empty)
    );

    uno_hand_ctrl #(.DEPTH(8), .INIT_CARDS(6)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_init(b_init), .i_start(b_start), .i_left(b_left),
        .i_right(b_right), .i_select(b_sel), .i_prev_card(b_prev), .i_draw_two(b_d2),
        .i_draw_four(b_d4), .o_draw(b_draw), .i_drawn(b_drawn), .i_drawed_card(b_dcard),
        .o_out(b_out), .o_out_card(b_out_card), .i_check(b_check), .o_hands(b_hands),
        .o_index(b_index), .o_count(b_count), .o_full(b_full), .o_empty(b_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hand model: sorted list of held codes.
    logic [5:0] model_q[$];

    task automatic model_ins(input logic [5:0] c);
        logic [5:0] cc;
        int pos;
        cc = c;
        if (c[3:0] == 4'd13 || c[3:0] == 4'd14) cc[5:4] = 2'b00;
        pos = 0;
        while (pos < model_q.size() && model_q[pos] < cc) pos++;
        model_q.insert(pos, cc);
    endtask

    function automatic logic [DEPTH*7-1:0] hands_exp();
        logic [DEPTH*7-1:0] v;
        v = '0;
        for (int k = 0; k < model_q.size(); k++) v[7*k +: 7] = {1'b1, model_q[k]};
        return v;
    endfunction

    task automatic chk_hands(input string nm);
        logic [DEPTH*7-1:0] e;
        e = hands_exp();
        n_checks++;
        if (hands !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, hands, e);
        end
    endtask

    // Deck responders: answer each o_draw one cycle later with the next queued card.
    logic [5:0] deck[$];
    logic [5:0] b_deck[$];
    int draws = 0;
    int b_draws = 0;
    bit deck_hold = 0;

    initial begin
        forever begin
            tick();
            while (draw && !deck_hold) begin
                draws++;
                tick();
                dcard = (deck.size() != 0) ? deck.pop_front() : 6'h01;
                drawn = 1'b1;
                tick();
                drawn = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            tick();
            while (b_draw) begin
                b_draws++;
                tick();
                b_dcard = (b_deck.size() != 0) ? b_deck.pop_front() : 6'h01;
                b_drawn = 1'b1;
                tick();
                b_drawn = 1'b0;
            end
        end
    end

    // Scoreboard: each expected played card is pushed before the triggering select.
    logic [5:0] exp_out_q[$];

    initial begin
        logic out_prev;
        logic [5:0] held;
        out_prev = 1'b0;
        held = '0;
        forever begin
            tick();
            if (out && !out_prev) begin
                if (exp_out_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got card %0h expected no play", out_card);
                end else begin
                    held = exp_out_q.pop_front();
                    chk("out_card", out_card, held);
                end
            end else if (out && out_prev) begin
                chk("out_card_hold", out_card, held);
            end
            out_prev = out;
        end
    end

    task automatic wait_draws(input int target, input string nm);
        int n;
        n = 0;
        while (draws < target && n < 400) begin
            tick();
            n++;
        end
        chk(nm, draws, target);
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        while (!out && n < 200) begin
            tick();
            n++;
        end
        chk(nm, out, 1);
    endtask

    task automatic pulse_sel();   sel = 1'b1;   tick(); sel = 1'b0;   endtask
    task automatic pulse_left();  left = 1'b1;  tick(); left = 1'b0;  endtask
    task automatic pulse_right(); right = 1'b1; tick(); right = 1'b0; endtask
    task automatic pulse_check(); check = 1'b1; tick(); check = 1'b0; endtask

    typedef struct {
        logic       l;
        logic       r;
        logic [3:0] idx;
    } nav_t;

    nav_t nav [7];

    initial begin
        int d0;
        // Cursor walk from index 0 with 6 cards held.
        nav[0] = '{l: 1'b1, r: 1'b0, idx: 4'd6};
        nav[1] = '{l: 1'b0, r: 1'b1, idx: 4'd0};
        nav[2] = '{l: 1'b0, r: 1'b1, idx: 4'd1};
        nav[3] = '{l: 1'b1, r: 1'b1, idx: 4'd1};
        nav[4] = '{l: 1'b0, r: 1'b1, idx: 4'd2};
        nav[5] = '{l: 1'b1, r: 1'b0, idx: 4'd1};
        nav[6] = '{l: 1'b1, r: 1'b0, idx: 4'd0};

        {init, start, left, right, sel, d2, d4, drawn, check} = '0;
        {b_init, b_start, b_left, b_right, b_sel, b_d2, b_d4, b_drawn, b_check} = '0;
        prev = '0; dcard = '0; b_prev = '0; b_dcard = '0;
        rst_n = 1'b0;
        repeat (3) tick();

        chk("rst_count", count, 0);
        chk("rst_index", index, 0);
        chk("rst_draw", draw, 0);
        chk("rst_out", out, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 0);
        chk("rst_out_card", out_card, 0);
        chk_hands("rst_hands");
        rst_n = 1'b1;
        tick();

        // Deal seven cards; the wild draw-four arrives coloured and is stored colourless.
        deck = '{6'h02, 6'h14, 6'h28, 6'h3B, 6'h00, 6'h28, 6'h3E};
        foreach (deck[i]) model_ins(deck[i]);
        init = 1'b1; tick(); init = 1'b0;
        wait_draws(7, "deal_draws");
        repeat (6) tick();
        chk("deal_draws_exact", draws, 7);
        chk("deal_count", count, 7);
        chk("deal_index", index, 0);
        chk("deal_empty", empty, 0);
        chk_hands("deal_hands");

        // Play red 0 on red 8.
        prev = 6'h08;
        start = 1'b1; tick();
        exp_out_q.push_back(6'h00);
        model_q.delete(0);
        pulse_sel();
        chk("play_out", out, 1);
        chk("play_count", count, 6);
        repeat (3) tick();
        chk("play_hold", out, 1);
        chk_hands("play_hands");
        pulse_check();
        chk("play_out_fall", out, 0);
        start = 1'b0; tick();

        // Reject a non-matching card, then walk the cursor.
        prev = 6'h33;
        start = 1'b1; tick();
        pulse_sel();
        tick();
        chk("reject_out", out, 0);
        chk("reject_count", count, 6);
        for (int i = 0; i < 7; i++) begin
            left = nav[i].l; right = nav[i].r;
            tick();
            left = 1'b0; right = 1'b0;
            chk($sformatf("nav%0d", i), index, nav[i].idx);
        end

        // Wild draw-four played as green.
        pulse_right();
        chk("wild_index", index, 1);
        pulse_sel();
        chk("wild_no_out_yet", out, 0);
        pulse_right();
        pulse_right();
        exp_out_q.push_back(6'h2E);
        model_q.delete(1);
        pulse_sel();
        chk("wild_out", out, 1);
        chk("wild_count", count, 5);
        chk_hands("wild_hands");
        pulse_check();
        start = 1'b0; tick();

        // Draw slot: pass after drawing yellow 5.
        start = 1'b1; tick();
        pulse_left();
        pulse_left();
        chk("drawslot_index", index, 5);
        deck.push_back(6'h15);
        model_ins(6'h15);
        exp_out_q.push_back(6'h3F);
        pulse_sel();
        wait_out("draw_out");
        chk("draw_count", count, 6);
        chk_hands("draw_hands");
        pulse_check();
        start = 1'b0; tick();

        // Draw-four penalty served before selecting.
        d4 = 1'b1; tick(); d4 = 1'b0;
        deck.push_back(6'h21); deck.push_back(6'h05);
        deck.push_back(6'h3D); deck.push_back(6'h17);
        model_ins(6'h21); model_ins(6'h05); model_ins(6'h3D); model_ins(6'h17);
        d0 = draws;
        start = 1'b1; tick();
        wait_draws(d0 + 4, "pen_draws");
        repeat (8) tick();
        chk("pen_draws_exact", draws, d0 + 4);
        chk("pen_count", count, 10);
        chk_hands("pen_hands");
        pulse_right();
        chk("pen_sel_index", index, 6);

        // Reset while a draw request is waiting for the deck.
        repeat (4) pulse_right();
        chk("pre_rst_index", index, 10);
        deck_hold = 1;
        pulse_sel();
        chk("req_draw", draw, 1);
        tick();
        chk("req_draw_drop", draw, 0);
        #3 rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_out_card", out_card, 0);
        chk("mid_rst_draw", draw, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_empty", empty, 0);
        chk_hands("mid_rst_hands");
        tick();
        rst_n = 1'b1;
        deck_hold = 0;
        tick();
        dcard = 6'h01; drawn = 1'b1; tick(); drawn = 1'b0;
        tick();
        chk("stray_drawn_count", count, 0);
        chk_hands("stray_drawn_hands");
        chk("scoreboard_drained", exp_out_q.size(), 0);

        // Small hand: penalty overflows, then the draw slot passes at once.
        b_deck = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};
        b_init = 1'b1; tick(); b_init = 1'b0;
        for (int n = 0; n < 200 && b_draws < 6; n++) tick();
        repeat (6) tick();
        chk("b_deal_draws", b_draws, 6);
        chk("b_deal_count", b_count, 6);
        chk("b_deal_full", b_full, 0);
        b_d4 = 1'b1; tick(); b_d4 = 1'b0;
        b_start = 1'b1; tick();
        repeat (30) tick();
        chk("b_pen_draws", b_draws, 8);
        chk("b_pen_count", b_count, 8);
        chk("b_pen_full", b_full, 1);
        b_left = 1'b1; tick(); b_left = 1'b0;
        chk("b_index_wrap", b_index, 8);
        b_sel = 1'b1; tick(); b_sel = 1'b0;
        chk("b_pass_out", b_out, 1);
        chk("b_pass_card", b_out_card, 6'h3F);
        chk("b_pass_no_draw", b_draws, 8);
        b_check = 1'b1; tick(); b_check = 1'b0;
        chk("b_out_fall", b_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
